// File: rtl/pipe_pkg.sv
// Shared EX->MEM pipeline definitions: control bit indices, default widths, payload layout.
package pipe_pkg;
  localparam int CTRL_REGFILE_WE = 0;
  localparam int CTRL_DATAMEM_WE = 1;

  localparam int DATA_W_DEF  = 32;
  localparam int RADDR_W_DEF = 5;
  localparam int CTRL_W_DEF  = 2;
  localparam int CNT_W_DEF   = 16;

  typedef struct packed {
    logic [CTRL_W_DEF-1:0]  ctrl;
    logic [RADDR_W_DEF-1:0] wr_addr;
    logic [DATA_W_DEF-1:0]  alu_out;
    logic [DATA_W_DEF-1:0]  wr_data;
    logic [RADDR_W_DEF-1:0] rd;
  } ex_mem_payload_t;

  // Flattened payload width, same field order as ex_mem_payload_t.
  function automatic int payload_w(input int dw, input int aw, input int cw);
    return cw + 2*aw + 2*dw;
  endfunction
endpackage

// File: rtl/pipe_entry.sv
// One pipeline entry: payload register plus valid flop; clear beats load.
module pipe_entry #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic         v,
  output logic [W-1:0] q
);
  logic         v_q;
  logic [W-1:0] q_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= 1'b0;
      q_q <= '0;
    end else begin
      if (clr)     v_q <= 1'b0;
      else if (ld) v_q <= 1'b1;
      if (ld)      q_q <= d;
    end
  end

  assign v = v_q;
  assign q = q_q;
endmodule

// File: rtl/ex_mem_skid.sv
// EX->MEM pipeline register with valid/ready handshake, optional skid entry,
// synchronous flush, valid-gated control bits and a saturating stall counter.
module ex_mem_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RADDR_W = RADDR_W_DEF,
  parameter int CTRL_W  = CTRL_W_DEF,
  parameter int SKID    = 1,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic [RADDR_W-1:0] in_wr_addr,
  input  logic [DATA_W-1:0]  in_alu_out,
  input  logic [DATA_W-1:0]  in_wr_data,
  input  logic [RADDR_W-1:0] in_rd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [RADDR_W-1:0] out_wr_addr,
  output logic [DATA_W-1:0]  out_alu_out,
  output logic [DATA_W-1:0]  out_wr_data,
  output logic [RADDR_W-1:0] out_rd,
  output logic [1:0]         occupancy,
  output logic [CNT_W-1:0]   stall_cnt
);
  localparam int PW = payload_w(DATA_W, RADDR_W, CTRL_W);

  logic [PW-1:0]    in_pl, main_d, main_q, skid_q;
  logic             main_v, skid_v, main_ld, main_clr;
  logic             acc, drn;
  logic [CNT_W-1:0] stall_d, stall_q;

  assign in_pl = {in_ctrl, in_wr_addr, in_alu_out, in_wr_data, in_rd};
  assign acc   = in_valid & in_ready;
  assign drn   = main_v & out_ready;

  // With SKID the ready is a flop output only; without it, MEM ready passes straight through.
  assign in_ready = (SKID != 0) ? ~skid_v : (~main_v | out_ready);

  always_comb begin
    main_ld  = (acc & (~main_v | drn)) | (drn & skid_v);
    main_clr = flush | (drn & ~skid_v & ~acc);
    main_d   = skid_v ? skid_q : in_pl;
  end

  pipe_entry #(.W(PW)) u_main (
    .clk(clk), .rst(rst), .ld(main_ld), .clr(main_clr),
    .d(main_d), .v(main_v), .q(main_q)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic skid_ld, skid_clr;
      // Skid is filled only when main is stalled; refill of main from skid empties it.
      assign skid_ld  = acc & main_v & ~drn;
      assign skid_clr = flush | (drn & skid_v);
      pipe_entry #(.W(PW)) u_skid (
        .clk(clk), .rst(rst), .ld(skid_ld), .clr(skid_clr),
        .d(in_pl), .v(skid_v), .q(skid_q)
      );
    end else begin : g_noskid
      assign skid_v = 1'b0;
      assign skid_q = '0;
    end
  endgenerate

  always_comb begin
    stall_d = stall_q;
    if (main_v && !out_ready && stall_q != {CNT_W{1'b1}}) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign out_valid   = main_v;
  assign out_ctrl    = main_q[PW-1 -: CTRL_W] & {CTRL_W{main_v}};
  assign out_wr_addr = main_q[RADDR_W+2*DATA_W +: RADDR_W];
  assign out_alu_out = main_q[RADDR_W+DATA_W +: DATA_W];
  assign out_wr_data = main_q[RADDR_W +: DATA_W];
  assign out_rd      = main_q[RADDR_W-1:0];
  assign occupancy   = {1'b0, main_v} + {1'b0, skid_v};
  assign stall_cnt   = stall_q;
endmodule

// File: tb/tb_ex_mem_skid.sv
// Bench for ex_mem_skid: three instances (skid, no skid, 4-bit counter) share stimulus;
// a queue-level model is compared every cycle, plus directed literal checks.
module tb_ex_mem_skid;
  import pipe_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  ex_mem_payload_t in_p = '0;

  int checks = 0, failures = 0;

  logic        ov[3], ir[3];
  logic [1:0]  oc[3], occ[3];
  logic [4:0]  owa[3], ord[3];
  logic [31:0] oal[3], owd[3];
  logic [15:0] sc0, sc1;
  logic [3:0]  sc_sat;

  ex_mem_skid #(.SKID(1)) u_s1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
    .in_ctrl(in_p.ctrl), .in_wr_addr(in_p.wr_addr), .in_alu_out(in_p.alu_out),
    .in_wr_data(in_p.wr_data), .in_rd(in_p.rd), .out_valid(ov[0]), .out_ready(out_ready),
    .out_ctrl(oc[0]), .out_wr_addr(owa[0]), .out_alu_out(oal[0]), .out_wr_data(owd[0]),
    .out_rd(ord[0]), .occupancy(occ[0]), .stall_cnt(sc0));

  ex_mem_skid #(.SKID(0)) u_s0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
    .in_ctrl(in_p.ctrl), .in_wr_addr(in_p.wr_addr), .in_alu_out(in_p.alu_out),
    .in_wr_data(in_p.wr_data), .in_rd(in_p.rd), .out_valid(ov[1]), .out_ready(out_ready),
    .out_ctrl(oc[1]), .out_wr_addr(owa[1]), .out_alu_out(oal[1]), .out_wr_data(owd[1]),
    .out_rd(ord[1]), .occupancy(occ[1]), .stall_cnt(sc1));

  ex_mem_skid #(.SKID(1), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[2]),
    .in_ctrl(in_p.ctrl), .in_wr_addr(in_p.wr_addr), .in_alu_out(in_p.alu_out),
    .in_wr_data(in_p.wr_data), .in_rd(in_p.rd), .out_valid(ov[2]), .out_ready(out_ready),
    .out_ctrl(oc[2]), .out_wr_addr(owa[2]), .out_alu_out(oal[2]), .out_wr_data(owd[2]),
    .out_rd(ord[2]), .occupancy(occ[2]), .stall_cnt(sc_sat));

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Model: each instance is a FIFO of at most 2 (skid) or 1 (no skid) beats.
  ex_mem_payload_t ment[3][2];
  int mn[3]   = '{0, 0, 0};
  int mcnt[3] = '{0, 0, 0};
  int mskid[3] = '{1, 0, 1};
  int mmax[3]  = '{65535, 65535, 15};

  function automatic bit mready(input int k);
    return (mskid[k] != 0) ? (mn[k] < 2) : (mn[k] == 0 || out_ready);
  endfunction

  function automatic logic [15:0] dut_sc(input int k);
    return (k == 0) ? sc0 : (k == 1) ? sc1 : {12'b0, sc_sat};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) begin mn[k] = 0; mcnt[k] = 0; end
    end else begin
      for (int k = 0; k < 3; k++) begin
        bit acc, drn;
        acc = in_valid && mready(k);
        drn = (mn[k] > 0) && out_ready;
        if (mn[k] > 0 && !out_ready && mcnt[k] < mmax[k]) mcnt[k]++;
        if (flush) mn[k] = 0;
        else begin
          if (drn) begin ment[k][0] = ment[k][1]; mn[k]--; end
          if (acc) begin ment[k][mn[k]] = in_p; mn[k]++; end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("m%0d out_valid", k), 128'(ov[k]), 128'(mn[k] > 0));
        check($sformatf("m%0d out_ctrl", k), 128'(oc[k]), 128'((mn[k] > 0) ? ment[k][0].ctrl : 2'b00));
        if (mn[k] > 0)
          check($sformatf("m%0d payload", k), 128'({oc[k], owa[k], oal[k], owd[k], ord[k]}), 128'(ment[k][0]));
        check($sformatf("m%0d in_ready", k), 128'(ir[k]), 128'(mready(k)));
        check($sformatf("m%0d occupancy", k), 128'(occ[k]), 128'(mn[k]));
        check($sformatf("m%0d stall_cnt", k), 128'(dut_sc(k)), 128'(mcnt[k]));
      end
    end
  end

  task automatic beat(input logic v, input logic [1:0] c, input logic [31:0] a,
                      input logic ordy, input logic fl);
    in_valid = v;
    in_p.ctrl = c;
    in_p.alu_out = a;
    in_p.wr_addr = a[4:0] ^ 5'h3;
    in_p.wr_data = ~a;
    in_p.rd = a[9:5] + 5'd1;
    out_ready = ordy;
    flush = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset values
    step(); step();
    check("rst out_valid", 128'(ov[0]), 128'(0));
    check("rst in_ready s1", 128'(ir[0]), 128'(1));
    check("rst in_ready s0", 128'(ir[1]), 128'(1));
    check("rst occupancy", 128'(occ[0]), 128'(0));
    #2 rst = 1'b0;

    // 1: reset during traffic
    beat(1, 2'b01, 32'h77, 0, 0);
    step(); step(); step();
    check("t1 out_valid pre", 128'(ov[0]), 128'(1));
    check("t1 stall pre", 128'(sc0), 128'(2));
    #2 rst = 1'b1;
    #1;
    check("t1 out_valid rst", 128'(ov[0]), 128'(0));
    check("t1 out_ctrl rst", 128'(oc[0]), 128'(0));
    check("t1 stall rst", 128'(sc0), 128'(0));
    check("t1 occ rst", 128'(occ[0]), 128'(0));
    #3 rst = 1'b0;
    beat(0, 0, 0, 1, 0);
    step();

    // 2: streaming
    beat(1, 0, 32'h10, 1, 0); step();
    check("t2 out 10", 128'(oal[0]), 128'(32'h10));
    check("t2 occ", 128'(occ[0]), 128'(1));
    beat(1, 0, 32'h20, 1, 0); step();
    check("t2 out 20", 128'(oal[0]), 128'(32'h20));
    check("t2 in_ready", 128'(ir[0]), 128'(1));
    beat(1, 0, 32'h30, 1, 0); step();
    check("t2 out 30", 128'(oal[0]), 128'(32'h30));
    beat(0, 0, 0, 1, 0); step();
    check("t2 drained", 128'(ov[0]), 128'(0));

    // 3: backpressure with skid
    rst = 1'b1; #2 rst = 1'b0;
    beat(1, 0, 32'hA, 0, 0); step();
    check("t3 out A", 128'(oal[0]), 128'(32'hA));
    check("t3 in_ready A", 128'(ir[0]), 128'(1));
    beat(1, 0, 32'hB, 0, 0); step();
    check("t3 hold A", 128'(oal[0]), 128'(32'hA));
    check("t3 occ 2", 128'(occ[0]), 128'(2));
    check("t3 in_ready 0", 128'(ir[0]), 128'(0));
    beat(1, 0, 32'hC, 0, 0); step(); step();
    check("t3 still A", 128'(oal[0]), 128'(32'hA));
    check("t3 stall 3", 128'(sc0), 128'(3));
    beat(1, 0, 32'hC, 1, 0); step();
    check("t3 out B", 128'(oal[0]), 128'(32'hB));
    check("t3 ready back", 128'(ir[0]), 128'(1));
    step();
    check("t3 out C", 128'(oal[0]), 128'(32'hC));
    beat(0, 0, 0, 1, 0); step();
    check("t3 empty", 128'(ov[0]), 128'(0));
    check("t3 stall final", 128'(sc0), 128'(3));

    // 4: flush with full skid and incoming beat
    beat(1, 2'b11, 32'h100, 0, 0); step();
    beat(1, 2'b11, 32'h101, 0, 0); step();
    check("t4 occ full", 128'(occ[0]), 128'(2));
    beat(1, 2'b11, 32'h102, 0, 1); step();
    check("t4 out_valid", 128'(ov[0]), 128'(0));
    check("t4 out_ctrl", 128'(oc[0]), 128'(0));
    check("t4 occ", 128'(occ[0]), 128'(0));
    beat(0, 0, 0, 1, 0);
    repeat (3) step();
    check("t4 no beat", 128'(ov[0]), 128'(0));

    // 5: no-skid pass-through ready
    beat(1, 2'b01, 32'h55, 0, 0); step();
    check("t5 out 55", 128'(oal[1]), 128'(32'h55));
    beat(1, 2'b01, 32'h66, 0, 0); #1;
    check("t5 in_ready low", 128'(ir[1]), 128'(0));
    out_ready = 1'b1; #1;
    check("t5 in_ready high", 128'(ir[1]), 128'(1));
    step();
    check("t5 out 66", 128'(oal[1]), 128'(32'h66));
    beat(0, 0, 0, 1, 0); step();

    // 6: counter saturation
    rst = 1'b1; #2 rst = 1'b0;
    beat(1, 2'b01, 32'h200, 0, 0);
    repeat (20) step();
    check("t6 sat 15", 128'(sc_sat), 128'(15));
    check("t6 wide 19", 128'(sc0), 128'(19));
    beat(0, 0, 0, 1, 0); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
